// File: rtl/operand_capture_if.sv
// operand_capture_if
// Bundles the raw board inputs (switches, centre button) and the captured
// operand outputs of operand_capture into one port. The slave modport is
// the capture block itself; the master modport is whoever drives the raw
// inputs and consumes the operands (board top level or a testbench).
interface operand_capture_if;
   logic [3:0] SW;         // raw switches: [1:0] = a, [3:2] = b
   logic       BTNC;       // raw centre button, active-high
   logic [1:0] a;          // captured operand a
   logic [1:0] b;          // captured operand b
   logic       op_valid;   // one-cycle strobe on each accepted press
   logic [3:0] cap_count;  // accepted presses, modulo 16

   modport master (
      output SW,
      output BTNC,
      input  a,
      input  b,
      input  op_valid,
      input  cap_count
   );

   modport slave (
      input  SW,
      input  BTNC,
      output a,
      output b,
      output op_valid,
      output cap_count
   );
endinterface

// File: rtl/operand_capture.sv
// operand_capture
// Input stage for the two-bit adder on the Nexys4 DDR board. The centre
// button and the four operand switches are brought into the CLK100MHZ
// domain through two-flop synchronizers. The button is then debounced by a
// four-state FSM. The operands are latched into held registers only when a
// debounced press is accepted, and op_valid pulses for that one cycle.
//
// Build option: define OPCAP_SW_DEBOUNCE_EN to give every switch bit its own
// debounce counter, so that operands come from debounced switch levels.
// When the macro is left undefined, operands are taken straight from the
// synchronized switches and no per-switch counters are built.
module operand_capture #(
   parameter int DEBOUNCE_CYCLES = 1000000   // stable cycles to accept a change, >= 1
) (
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   operand_capture_if.slave   bus
);

   // One extra count of headroom so that the counter can hold DEBOUNCE_CYCLES itself.
   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,   // debounced level 0
      PRESS_CHK = 2'd1,   // button seen high, counting toward an accepted press
      HELD      = 2'd2,   // debounced level 1
      REL_CHK   = 2'd3    // button seen low, counting toward an accepted release
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   logic       btn_meta;
   logic       btn_sync;
   logic [3:0] sw_meta;
   logic [3:0] sw_sync;

   // Two-flop synchronizers for the button and each switch bit.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         sw_meta  <= 4'b0000;
         sw_sync  <= 4'b0000;
      end else begin
         btn_meta <= bus.BTNC;
         btn_sync <= btn_meta;
         sw_meta  <= bus.SW;
         sw_sync  <= sw_meta;
      end
   end

   // ------------------------------------------------------------------
   // Operand source
   // ------------------------------------------------------------------
   logic [3:0] op_src;   // switch values that a capture loads into a/b

`ifdef OPCAP_SW_DEBOUNCE_EN
   logic [3:0] sw_level;   // debounced switch levels

   // One independent debouncer per switch bit. Each debouncer follows the
   // same consecutive-cycle rule as the button: any cycle in which the
   // input agrees with the held level restarts the count.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sw_deb
      logic [CNT_W-1:0] sw_cnt;
      logic             level_bit;

      // Count cycles of disagreement; flip the level once the count reaches the limit.
      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
         if (!CPU_RESETN) begin
            sw_cnt    <= '0;
            level_bit <= 1'b0;
         end else if (sw_sync[gi] == level_bit) begin
            sw_cnt <= '0;
         end else if (sw_cnt == CNT_MAX) begin
            sw_cnt    <= '0;
            level_bit <= sw_sync[gi];
         end else begin
            sw_cnt <= sw_cnt + 1'b1;
         end
      end

      assign sw_level[gi] = level_bit;
   end

   assign op_src = sw_level;
`else
   assign op_src = sw_sync;
`endif

   // ------------------------------------------------------------------
   // Button debounce FSM and capture registers
   // ------------------------------------------------------------------
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       a_reg;
   logic [1:0]       b_reg;
   logic             op_valid_reg;
   logic [3:0]       cap_count_reg;

   // The debounce FSM also owns the registered outputs. Only the
   // PRESS_CHK->HELD transition loads the operands and raises op_valid.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state         <= IDLE;
         cnt           <= '0;
         a_reg         <= 2'b00;
         b_reg         <= 2'b00;
         op_valid_reg  <= 1'b0;
         cap_count_reg <= 4'd0;
      end else begin
         op_valid_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (btn_sync) begin
                  // The first differing sample already counts as one cycle.
                  state <= PRESS_CHK;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end

            PRESS_CHK: begin
               if (!btn_sync) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state         <= HELD;
                  cnt           <= '0;
                  a_reg         <= op_src[1:0];
                  b_reg         <= op_src[3:2];
                  op_valid_reg  <= 1'b1;
                  cap_count_reg <= cap_count_reg + 4'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            HELD: begin
               if (!btn_sync) begin
                  state <= REL_CHK;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end

            REL_CHK: begin
               if (btn_sync) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  // A release is accepted silently: no capture and no strobe.
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.a         = a_reg;
   assign bus.b         = b_reg;
   assign bus.op_valid  = op_valid_reg;
   assign bus.cap_count = cap_count_reg;

endmodule

// File: doc/operand_capture.md
# operand_capture

Upstream input stage for the two-bit adder on the Nexys4 DDR board. Synchronizes and debounces the centre push-button and captures the four operand switches into held registers `a[1:0]` and `b[1:0]`. Emits a one-cycle `op_valid` strobe on each accepted press. The adder therefore sees stable, glitch-free operands that change only on a deliberate button press, not on every switch bounce.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 1.
- `CLK100MHZ` input 1: system clock, all logic on rising edge.
- `CPU_RESETN` input 1: reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `SW` input 4: raw switches; `SW[1:0]` = a, `SW[3:2]` = b (bit 0 LSB of a, bit 2 LSB of b).
- `BTNC` input 1: raw centre button, active-high.
- `a` output 2: captured operand a.
- `b` output 2: captured operand b.
- `op_valid` output 1: single-cycle strobe, high in the cycle `a`/`b` first show newly captured values.
- `cap_count` output 4: number of accepted presses, modulo 16.

## Operation
- `BTNC` and each `SW` bit pass through a two-flop synchronizer; all later logic uses synchronized values only.
- Button debounce: counter `cnt` of width clog2(DEBOUNCE_CYCLES+1) increments each cycle the synchronized button differs from the debounced level. Any cycle of equality clears `cnt` to 0.
- FSM states and transitions:
  - IDLE: debounced level 0, `cnt` = 0. Synced button = 1 → PRESS_CHK.
  - PRESS_CHK: counting toward press. Synced button = 0 → IDLE with `cnt` cleared. `cnt` reaching DEBOUNCE_CYCLES → HELD.
  - HELD: debounced level 1. Synced button = 0 → REL_CHK.
  - REL_CHK: synced button = 1 → HELD with `cnt` cleared. `cnt` reaching DEBOUNCE_CYCLES → IDLE.
- Only the PRESS_CHK→HELD edge produces a capture: load `a` ← operand source bits [1:0], `b` ← [3:2], set `op_valid` = 1 for exactly one cycle, and increment `cap_count` (15 wraps to 0).
- Releasing the button never captures and never pulses `op_valid`.
- Switch changes while HELD, REL_CHK or IDLE do not affect `a`/`b` until the next accepted press.
- Reset values: `a` = 0, `b` = 0, `op_valid` = 0, `cap_count` = 0, FSM = IDLE, `cnt` = 0, synchronizers = 0, debounced switch levels = 0.
- Reset mid-operation (any state): all outputs go to reset values immediately and asynchronously, and no pending capture completes. After deassertion, a still-held button is treated as a fresh press and is captured after full latency.

## Timing
- Press latency: a clean `BTNC` rise sampled at edge 0 gives `op_valid` high in the cycle after edge 2 + DEBOUNCE_CYCLES, i.e., DEBOUNCE_CYCLES + 2 cycles of synchronizer plus debounce.
- `a`, `b` and `cap_count` update on the same edge that raises `op_valid`; `op_valid` falls on the next edge.
- The minimum interval between two `op_valid` pulses is 2·DEBOUNCE_CYCLES + 2 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `OPCAP_SW_DEBOUNCE_EN`.
- Defined: each `SW` bit has its own counter and debounced level using the same consecutive-cycle rule. Captured operands come from the debounced switch levels, so a switch changed less than DEBOUNCE_CYCLES + 2 cycles before the press is accepted still captures its old value.
- Undefined: operands are captured directly from the two-flop-synchronized switches, and no per-switch counters are built.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: `CPU_RESETN` = 0 with `SW` = 4'b1111 and `BTNC` = 1 → `a` = 0, `b` = 0, `op_valid` = 0, `cap_count` = 0, held for the whole reset.
- Clean press: `SW` = 4'b1011 stable, `BTNC` high for 20 cycles → one `op_valid` pulse 6 cycles after rise; `a` = 2'b11, `b` = 2'b10, `cap_count` = 1. Release → no pulse.
- Bounce rejection: `BTNC` pattern high 3, low 1, high 3, low 10 cycles → no `op_valid`, `a`/`b`/`cap_count` unchanged.
- Hold isolation: during HELD change `SW` to 4'b0100 → `a`/`b` unchanged. Release, then press 10 cycles → `a` = 2'b00, `b` = 2'b01, `cap_count` = 2.
- Reset mid-press: assert reset 3 cycles into PRESS_CHK, deassert with `BTNC` still high → outputs zero during reset. Single `op_valid` 6 cycles after deassertion, `cap_count` = 1.
- Wrap: 16 clean press/release pairs → `cap_count` returns to 0 with exactly 16 `op_valid` pulses. With `OPCAP_SW_DEBOUNCE_EN` defined, a `SW` change 2 cycles before the press edge is not captured.
